etc_result_drain: RTL and testbench

Result-side companion to the 4x4 extended tensor core (`etc`). It tracks tile issues into the core, captures each 4x4 result tile when it emerges from the core's fixed two-stage pipeline, and buffers up to two tiles. It then streams the results one element per beat over a valid/ready interface toward writeback. It sits between the `etc` output bus and the result-store path, and gives the issuing controller back-pressure through `issue_ready`.

---
 rtl/etc_pkg.sv | 23 ++
 rtl/etc_result_drain_if.sv | 19 +
 rtl/etc_tile_buf.sv | 57 +++++
 rtl/etc_result_drain.sv | 118 +++++++++++
 tb/tb_etc_result_drain.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/etc_pkg.sv
`default_nettype none
//==============================================================================
// Module  : etc_pkg
// Shared constants, tile type and drain state encoding for the etc result path.
// Revision: 1.0
//==============================================================================
package etc_pkg;

    localparam int ETC_N   = 4;
    localparam int ETC_LAT = 2;
    localparam int ETC_W   = 16;

    // Reference tile type at the default element width; parameterised modules
    // declare the same shape with their own W.
    typedef logic [ETC_N-1:0][ETC_N-1:0][ETC_W-1:0] etc_tile_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/etc_result_drain_if.sv
`default_nettype none
//==============================================================================
// Module  : etc_result_drain_if
// Element stream (valid/ready) from the result drain toward writeback.
// Revision: 1.0
//==============================================================================
interface etc_result_drain_if #(
    parameter int W = 16
);
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic [3:0]   m_idx;
    logic         m_last;

    modport master (output m_valid, output m_data, output m_idx, output m_last, input  m_ready);
    modport slave  (input  m_valid, input  m_data, input  m_idx, input  m_last, output m_ready);
endinterface
`default_nettype wire

// File: rtl/etc_tile_buf.sv
`default_nettype none
//==============================================================================
// Module  : etc_tile_buf
// Two-entry tile FIFO; push and pop in the same cycle keep the count unchanged.
// Revision: 1.0
//==============================================================================
module etc_tile_buf
    import etc_pkg::*;
#(
    parameter int W = 16
) (
    input  wire logic                                clk,
    input  wire logic                                rst_n,
    input  wire logic                                i_push,
    input  wire logic                                i_pop,
    input  wire logic [ETC_N-1:0][ETC_N-1:0][W-1:0]  i_wrTile,
    output logic      [ETC_N-1:0][ETC_N-1:0][W-1:0]  o_head,
    output logic                                     o_full,
    output logic                                     o_empty,
    output logic      [1:0]                          o_count
);

    logic [ETC_N-1:0][ETC_N-1:0][W-1:0] r_mem [2];
    logic                               r_wrPtr;
    logic                               r_rdPtr;
    logic [1:0]                         r_count;

    // Storage needs no reset: contents are only visible while the count is non-zero.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wrPtr] <= i_wrTile;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) r_wrPtr <= ~r_wrPtr;
            if (i_pop)  r_rdPtr <= ~r_rdPtr;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/etc_result_drain.sv
`default_nettype none
//==============================================================================
// Module  : etc_result_drain
// Captures etc result tiles and streams them one element per beat.
// Build option: ETC_DRAIN_COLMAJOR_EN selects column-major emission order.
// Revision: 1.0
//==============================================================================
module etc_result_drain
    import etc_pkg::*;
#(
    parameter int W = 16
) (
    input  wire logic                                clk,
    input  wire logic                                rst_n,
    input  wire logic                                issue,
    output logic                                     issue_ready,
    input  wire logic [ETC_N-1:0][ETC_N-1:0][W-1:0]  tile_in,
    etc_result_drain_if.master                       m,
    output logic                                     ovf,
    input  wire logic                                ovf_clr,
    output logic                                     busy
);

    drain_state_t                       r_state;
    drain_state_t                       w_nextState;
    logic [ETC_LAT-1:0]                 r_vld;
    logic [3:0]                         r_idx;
    logic                               r_ovf;
    logic [ETC_N-1:0][ETC_N-1:0][W-1:0] w_head;
    logic                               w_bufFull;
    logic                               w_bufEmpty;
    logic [1:0]                         w_bufCount;
    logic [2:0]                         w_credits;
    logic                               w_issueAcc;
    logic                               w_drop;
    logic                               w_push;
    logic                               w_valid;
    logic                               w_beatAcc;
    logic                               w_lastBeat;
    logic                               w_pop;
    logic [1:0]                         w_row;
    logic [1:0]                         w_col;

    // Credits cover both tiles still inside etc and tiles already buffered,
    // so a capture can never find the FIFO full.
    assign w_credits   = {2'b00, r_vld[0]} + {2'b00, r_vld[ETC_LAT-1]} + {1'b0, w_bufCount};
    assign issue_ready = (w_credits < 3'd2);
    assign w_issueAcc  = issue &  issue_ready;
    assign w_drop      = issue & ~issue_ready;
    assign w_push      = r_vld[ETC_LAT-1];

    assign w_beatAcc   = w_valid & m.m_ready;
    assign w_lastBeat  = (r_idx == 4'd15);
    assign w_pop       = w_beatAcc & w_lastBeat;

    etc_tile_buf #(
        .W (W)
    ) u_tile_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_wrTile (tile_in),
        .o_head   (w_head),
        .o_full   (w_bufFull),
        .o_empty  (w_bufEmpty),
        .o_count  (w_bufCount)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_vld   <= '0;
            r_idx   <= 4'd0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_vld   <= {r_vld[ETC_LAT-2:0], w_issueAcc};
            if (w_beatAcc) r_idx <= r_idx + 4'd1;
            if (w_drop)       r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_push) w_nextState = STREAM;
            end
            STREAM: begin
                w_valid = 1'b1;
                // Leave only when the popped tile was the last one and none lands now.
                if (w_pop && !w_push && !w_bufFull) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

`ifdef ETC_DRAIN_COLMAJOR_EN
    assign w_row = r_idx[1:0];
    assign w_col = r_idx[3:2];
`else
    assign w_row = r_idx[3:2];
    assign w_col = r_idx[1:0];
`endif

    assign m.m_valid = w_valid;
    assign m.m_data  = w_valid ? w_head[w_row][w_col] : '0;
    assign m.m_idx   = w_valid ? {w_row, w_col} : 4'd0;
    assign m.m_last  = w_valid & w_lastBeat;

    assign ovf  = r_ovf;
    assign busy = (r_vld != '0) || !w_bufEmpty;

endmodule
`default_nettype wire

// File: tb/tb_etc_result_drain.sv
`default_nettype none
//==============================================================================
// Module  : tb_etc_result_drain
// Directed and random stimulus against a tile-queue reference model.
// Revision: 1.0
//==============================================================================
module tb_etc_result_drain;

    localparam int W = 16;
    typedef logic [3:0][3:0][W-1:0] tile_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b1;
    logic  issue = 1'b0;
    logic  ovf_clr = 1'b0;
    logic  issueReady, ovf, busy;
    tile_t tileIn, inA, inB, s1, s2;

    etc_result_drain_if #(.W(W)) mIf ();

    etc_result_drain #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue       (issue),
        .issue_ready (issueReady),
        .tile_in     (tileIn),
        .m           (mIf.master),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic tile_t matmul(input tile_t a, input tile_t b);
        tile_t p;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                p[r][c] = '0;
                for (int k = 0; k < 4; k++) p[r][c] = p[r][c] + a[r][k] * b[k][c];
            end
        return p;
    endfunction

    function automatic tile_t randTile();
        tile_t t;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r][c] = W'($urandom);
        return t;
    endfunction

    // Environment stand-in for etc: unreset two-stage product pipeline.
    always @(posedge clk) begin
        s1 <= matmul(inA, inB);
        s2 <= s1;
    end
    assign tileIn = s2;

    // Reference model: tiles awaiting emission, each with the cycle it becomes visible.
    tile_t expQ[$];
    int    availQ[$];
    int    beatPos = 0;
    int    outstanding = 0;
    bit    expOvf = 1'b0;
    int    cyc = 0;
    int    nAssert = 0;
    int    nFail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit    expValid, expReady, accIssue, beatAcc, drop, clr;
        int    r, c;
        tile_t newTile;
        expReady = (outstanding < 2);
        expValid = (expQ.size() > 0) && (availQ[0] <= cyc);
        chk("issue_ready", 32'(issueReady), 32'(expReady));
        chk("m_valid", 32'(mIf.m_valid), 32'(expValid));
        chk("ovf", 32'(ovf), 32'(expOvf));
        chk("busy", 32'(busy), 32'(outstanding != 0));
        if (expValid) begin
`ifdef ETC_DRAIN_COLMAJOR_EN
            r = beatPos % 4; c = beatPos / 4;
`else
            r = beatPos / 4; c = beatPos % 4;
`endif
            chk("m_data", 32'(mIf.m_data), 32'(expQ[0][r][c]));
            chk("m_idx", 32'(mIf.m_idx), 32'(r * 4 + c));
            chk("m_last", 32'(mIf.m_last), 32'(beatPos == 15));
        end
        accIssue = issue && expReady;
        drop     = issue && !expReady;
        beatAcc  = expValid && mIf.m_ready;
        clr      = ovf_clr;
        newTile  = matmul(inA, inB);
        @(posedge clk);
        if (beatAcc) begin
            beatPos++;
            if (beatPos == 16) begin
                beatPos = 0;
                void'(expQ.pop_front());
                void'(availQ.pop_front());
                outstanding--;
            end
        end
        if (accIssue) begin
            expQ.push_back(newTile);
            availQ.push_back(cyc + 3);
            outstanding++;
        end
        if (drop)     expOvf = 1'b1;
        else if (clr) expOvf = 1'b0;
        cyc++;
        #1;
    endtask

    task automatic issueTile(input tile_t a, input tile_t b);
        inA = a; inB = b; issue = 1'b1;
        tick();
        issue = 1'b0; inA = randTile(); inB = randTile();
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic checkResetValues(input string tag);
        chk({tag, "_m_valid"}, 32'(mIf.m_valid), 32'd0);
        chk({tag, "_m_data"}, 32'(mIf.m_data), 32'd0);
        chk({tag, "_m_idx"}, 32'(mIf.m_idx), 32'd0);
        chk({tag, "_m_last"}, 32'(mIf.m_last), 32'd0);
        chk({tag, "_issue_ready"}, 32'(issueReady), 32'd1);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic drainAll();
        int guard = 0;
        issue = 1'b0; mIf.m_ready = 1'b1;
        while (outstanding != 0 && guard < 200) begin tick(); guard++; end
        chk("drain_bound", 32'(outstanding), 32'd0);
        tick();
    endtask

    tile_t idA, seqB, dblB;
    logic [3:0] readyPat;

    initial begin
        mIf.m_ready = 1'b1;
        inA = randTile(); inB = randTile();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                idA[r][c]  = (r == c) ? W'(1) : W'(0);
                seqB[r][c] = W'(4 * r + c + 1);
                dblB[r][c] = W'(2 * (4 * r + c + 1));
            end

        // Power-on reset
        #1 rst_n = 1'b0;
        #1 checkResetValues("por");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single tile, sink always ready
        issueTile(idA, seqB);
        runTicks(20);

        // Back-to-back tiles stream without a gap
        issueTile(idA, seqB);
        issueTile(idA, dblB);
        runTicks(36);

        // Stalling sink: ready pattern 1,0,0,1
        readyPat = 4'b1001;
        issueTile(idA, seqB);
        for (int i = 0; i < 72; i++) begin
            mIf.m_ready = readyPat[i % 4];
            tick();
        end
        drainAll();

        // Third issue while two tiles pending is dropped
        issueTile(idA, seqB);
        issueTile(idA, dblB);
        issueTile(randTile(), randTile());
        drainAll();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        tick();

        // Drop and clear in the same cycle: the drop wins
        issueTile(idA, seqB);
        issueTile(idA, dblB);
        ovf_clr = 1'b1;
        issueTile(randTile(), randTile());
        ovf_clr = 1'b0;
        drainAll();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        tick();

        // Reset in the middle of the first tile
        issueTile(idA, seqB);
        issueTile(idA, dblB);
        for (int g = 0; g < 20 && !(beatPos == 5 && outstanding == 2); g++) tick();
        chk("pre_reset_beat", 32'(beatPos), 32'd5);
        #2 rst_n = 1'b0;
        #1 checkResetValues("mid");
        expQ.delete(); availQ.delete();
        beatPos = 0; outstanding = 0; expOvf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        issueTile(idA, dblB);
        runTicks(20);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            issue       = ($urandom_range(0, 2) == 0);
            inA         = randTile();
            inB         = randTile();
            mIf.m_ready = ($urandom_range(0, 3) != 0);
            ovf_clr     = ($urandom_range(0, 15) == 0);
            tick();
        end
        ovf_clr = 1'b0;
        drainAll();

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
`default_nettype wire
